// File: rtl/mdu_if.sv
// Handshake and datapath bundle between the EX stage / ALU and the HI/LO sequencer.
// master = pipeline + ALU side, slave = mdu_sequencer.
interface mdu_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        flush;
    logic        stall;
    logic [31:0] rd_data;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic [31:0] alu_result2;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0;

    modport master (
        output req_valid, req_op, req_x, req_y, flush, alu_result, alu_result2,
        input  stall, rd_data, alu_x, alu_y, alu_op, hi, lo, busy, done, div0
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, flush, alu_result, alu_result2,
        output stall, rd_data, alu_x, alu_y, alu_op, hi, lo, busy, done, div0
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/DIV sequencer: holds ALU operands for a fixed latency, then
// commits Result2/Result into HI/LO. Also serves MTHI/MTLO/MFHI/MFLO.
module mdu_sequencer #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 16
) (
    input logic  clk,
    input logic  rst,
    mdu_if.slave mdu
);
    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_MTHI = 3'd2;
    localparam logic [2:0] OP_MTLO = 3'd3;
    localparam logic [2:0] OP_MFHI = 3'd4;
    localparam logic [2:0] OP_MFLO = 3'd5;

    localparam logic [3:0] ALU_MULT = 4'd3;
    localparam logic [3:0] ALU_DIV  = 4'd4;
    localparam logic [3:0] ALU_IDLE = 4'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0] hi_r, hi_nxt;
    logic [31:0] lo_r, lo_nxt;
    logic [31:0] alu_x_r, alu_x_nxt;
    logic [31:0] alu_y_r, alu_y_nxt;
    logic [3:0]  alu_op_r, alu_op_nxt;
    logic        busy_r, done_r, done_nxt, div0_r, div0_nxt;
    logic [CNT_W-1:0] lat_sel_c;

    assign lat_sel_c = (mdu.req_op == OP_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            alu_x_r  <= '0;
            alu_y_r  <= '0;
            alu_op_r <= ALU_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            div0_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            hi_r     <= hi_nxt;
            lo_r     <= lo_nxt;
            alu_x_r  <= alu_x_nxt;
            alu_y_r  <= alu_y_nxt;
            alu_op_r <= alu_op_nxt;
            busy_r   <= (state_nxt != S_IDLE);
            done_r   <= done_nxt;
            div0_r   <= div0_nxt;
        end
    end

    // Next-state and register-input logic; flush outranks every other event
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hi_nxt     = hi_r;
        lo_nxt     = lo_r;
        alu_x_nxt  = alu_x_r;
        alu_y_nxt  = alu_y_r;
        alu_op_nxt = alu_op_r;
        done_nxt   = 1'b0;
        div0_nxt   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (mdu.req_valid && !mdu.flush) begin
                    case (mdu.req_op)
                        OP_MULT, OP_DIV: begin
                            alu_x_nxt  = mdu.req_x;
                            alu_y_nxt  = mdu.req_y;
                            alu_op_nxt = (mdu.req_op == OP_DIV) ? ALU_DIV : ALU_MULT;
                            cnt_nxt    = lat_sel_c - CNT_W'(1);
                            state_nxt  = (lat_sel_c == CNT_W'(1)) ? S_WB : S_RUN;
                        end
                        OP_MTHI: hi_nxt = mdu.req_x;
                        OP_MTLO: lo_nxt = mdu.req_x;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (mdu.flush) begin
                    state_nxt  = S_IDLE;
                    cnt_nxt    = '0;
                    alu_op_nxt = ALU_IDLE;
                end else begin
                    // RUN spans LAT-1 cycles so the write lands LAT cycles after acceptance
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                state_nxt  = S_IDLE;
                cnt_nxt    = '0;
                alu_op_nxt = ALU_IDLE;
                if (!mdu.flush) begin
                    if (alu_op_r == ALU_DIV && alu_y_r == 32'd0) begin
                        div0_nxt = 1'b1;
                    end else begin
                        hi_nxt   = mdu.alu_result2;
                        lo_nxt   = mdu.alu_result;
                        done_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Any HI/LO-class op waits behind an in-flight MULT/DIV to keep ordering
    assign mdu.stall   = mdu.req_valid && busy_r && (mdu.req_op <= OP_MFLO);
    assign mdu.rd_data = !mdu.req_valid          ? 32'd0 :
                         (mdu.req_op == OP_MFHI) ? hi_r  :
                         (mdu.req_op == OP_MFLO) ? lo_r  : 32'd0;

    assign mdu.alu_x  = alu_x_r;
    assign mdu.alu_y  = alu_y_r;
    assign mdu.alu_op = alu_op_r;
    assign mdu.hi     = hi_r;
    assign mdu.lo     = lo_r;
    assign mdu.busy   = busy_r;
    assign mdu.done   = done_r;
    assign mdu.div0   = div0_r;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with a behavioural signed-multiply / unsigned-divide ALU.
module tb_mdu_sequencer;
    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_MTHI = 3'd2;
    localparam logic [2:0] OP_MTLO = 3'd3;
    localparam logic [2:0] OP_MFHI = 3'd4;
    localparam logic [2:0] OP_MFLO = 3'd5;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n;
    int   dn;

    mdu_if mdu_bus ();

    mdu_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: op 3 signed 32x32->64, op 4 unsigned divide (y==0 gives all-ones / x)
    logic [63:0] sx, sy, prod;
    assign sx   = {{32{mdu_bus.alu_x[31]}}, mdu_bus.alu_x};
    assign sy   = {{32{mdu_bus.alu_y[31]}}, mdu_bus.alu_y};
    assign prod = sx * sy;
    always_comb begin
        mdu_bus.alu_result  = 32'd0;
        mdu_bus.alu_result2 = 32'd0;
        if (mdu_bus.alu_op == 4'd3) begin
            mdu_bus.alu_result  = prod[31:0];
            mdu_bus.alu_result2 = prod[63:32];
        end else if (mdu_bus.alu_op == 4'd4) begin
            if (mdu_bus.alu_y == 32'd0) begin
                mdu_bus.alu_result  = 32'hFFFF_FFFF;
                mdu_bus.alu_result2 = mdu_bus.alu_x;
            end else begin
                mdu_bus.alu_result  = mdu_bus.alu_x / mdu_bus.alu_y;
                mdu_bus.alu_result2 = mdu_bus.alu_x % mdu_bus.alu_y;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        mdu_bus.req_valid = v;
        mdu_bus.req_op    = op;
        mdu_bus.req_x     = x;
        mdu_bus.req_y     = y;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        mdu_bus.flush = 1'b0;
        drive(1'b0, OP_MULT, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_hi",     mdu_bus.hi, 32'd0);
        check_eq("rst_lo",     mdu_bus.lo, 32'd0);
        check_eq("rst_alu_op", 32'(mdu_bus.alu_op), 32'd5);
        check_eq("rst_busy",   32'(mdu_bus.busy), 32'd0);
        check_eq("rst_done",   32'(mdu_bus.done), 32'd0);
        check_eq("rst_stall",  32'(mdu_bus.stall), 32'd0);
        rst = 1'b0;
        step();

        // MULT -2 * 3 with an MFHI queued behind it
        drive(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3);
        step();
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        #1;
        check_eq("mul_busy",   32'(mdu_bus.busy), 32'd1);
        check_eq("mul_alu_op", 32'(mdu_bus.alu_op), 32'd3);
        check_eq("mul_alu_x",  mdu_bus.alu_x, 32'hFFFF_FFFE);
        n  = 0;
        dn = 0;
        while (mdu_bus.stall && n < 64) begin
            if (mdu_bus.done) dn++;
            n++;
            step();
        end
        check_eq("mul_stall_cycles", 32'(n), 32'd4);
        check_eq("mul_done_early",   32'(dn), 32'd0);
        check_eq("mul_done",   32'(mdu_bus.done), 32'd1);
        check_eq("mul_hi",     mdu_bus.hi, 32'hFFFF_FFFF);
        check_eq("mul_lo",     mdu_bus.lo, 32'hFFFF_FFFA);
        check_eq("mul_mfhi",   mdu_bus.rd_data, 32'hFFFF_FFFF);
        check_eq("mul_alu_op_idle", 32'(mdu_bus.alu_op), 32'd5);
        step();
        check_eq("mul_done_once", 32'(mdu_bus.done), 32'd0);

        // DIV 100 / 7 with an MFLO queued behind it
        drive(1'b1, OP_DIV, 32'd100, 32'd7);
        step();
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        #1;
        check_eq("div_alu_op", 32'(mdu_bus.alu_op), 32'd4);
        check_eq("div_alu_y",  mdu_bus.alu_y, 32'd7);
        n = 0;
        while (mdu_bus.stall && n < 64) begin
            n++;
            step();
        end
        check_eq("div_stall_cycles", 32'(n), 32'd16);
        check_eq("div_lo",   mdu_bus.lo, 32'd14);
        check_eq("div_hi",   mdu_bus.hi, 32'd2);
        check_eq("div_mflo", mdu_bus.rd_data, 32'd14);
        check_eq("div_done", 32'(mdu_bus.done), 32'd1);
        step();
        drive(1'b0, OP_MULT, 32'd0, 32'd0);

        // MTHI / MTLO back to back, then read both
        drive(1'b1, OP_MTHI, 32'h1234_5678, 32'd0);
        #1;
        check_eq("mthi_stall", 32'(mdu_bus.stall), 32'd0);
        step();
        check_eq("mthi_hi", mdu_bus.hi, 32'h1234_5678);
        drive(1'b1, OP_MTLO, 32'h9ABC_DEF0, 32'd0);
        #1;
        check_eq("mtlo_stall", 32'(mdu_bus.stall), 32'd0);
        step();
        check_eq("mtlo_lo", mdu_bus.lo, 32'h9ABC_DEF0);
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        #1;
        check_eq("mfhi_rd", mdu_bus.rd_data, 32'h1234_5678);
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        #1;
        check_eq("mflo_rd", mdu_bus.rd_data, 32'h9ABC_DEF0);
        check_eq("mflo_stall", 32'(mdu_bus.stall), 32'd0);
        step();

        // Flush in IDLE suppresses an MTHI
        drive(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        mdu_bus.flush = 1'b1;
        step();
        mdu_bus.flush = 1'b0;
        drive(1'b0, OP_MULT, 32'd0, 32'd0);
        check_eq("idle_flush_hi", mdu_bus.hi, 32'h1234_5678);

        // DIV by zero after MTLO 0x55; reserved op never stalls
        drive(1'b1, OP_MTLO, 32'h55, 32'd0);
        step();
        drive(1'b1, OP_DIV, 32'd9, 32'd0);
        step();
        drive(1'b1, 3'd7, 32'd0, 32'd0);
        #1;
        check_eq("rsvd_stall", 32'(mdu_bus.stall), 32'd0);
        drive(1'b0, OP_MULT, 32'd0, 32'd0);
        n = 0;
        while (mdu_bus.busy && n < 64) begin
            n++;
            step();
        end
        check_eq("div0_busy_cycles", 32'(n), 32'd16);
        check_eq("div0_pulse", 32'(mdu_bus.div0), 32'd1);
        check_eq("div0_done",  32'(mdu_bus.done), 32'd0);
        check_eq("div0_lo",    mdu_bus.lo, 32'h55);
        check_eq("div0_hi",    mdu_bus.hi, 32'h1234_5678);
        step();
        check_eq("div0_once",  32'(mdu_bus.div0), 32'd0);

        // MULT 5*5 flushed on its second RUN cycle
        drive(1'b1, OP_MULT, 32'd5, 32'd5);
        step();
        drive(1'b0, OP_MULT, 32'd0, 32'd0);
        step();
        mdu_bus.flush = 1'b1;
        step();
        mdu_bus.flush = 1'b0;
        check_eq("run_flush_busy",   32'(mdu_bus.busy), 32'd0);
        check_eq("run_flush_alu_op", 32'(mdu_bus.alu_op), 32'd5);
        dn = 0;
        repeat (4) begin
            if (mdu_bus.done) dn++;
            step();
        end
        check_eq("run_flush_no_done", 32'(dn), 32'd0);
        check_eq("run_flush_hi", mdu_bus.hi, 32'h1234_5678);
        check_eq("run_flush_lo", mdu_bus.lo, 32'h55);

        // MULT 5*5 flushed in its WB cycle
        drive(1'b1, OP_MULT, 32'd5, 32'd5);
        step();
        drive(1'b0, OP_MULT, 32'd0, 32'd0);
        repeat (3) step();
        mdu_bus.flush = 1'b1;
        step();
        mdu_bus.flush = 1'b0;
        check_eq("wb_flush_done", 32'(mdu_bus.done), 32'd0);
        check_eq("wb_flush_busy", 32'(mdu_bus.busy), 32'd0);
        check_eq("wb_flush_lo",   mdu_bus.lo, 32'h55);

        // Asynchronous reset in the middle of a DIV
        drive(1'b1, OP_DIV, 32'd100, 32'd7);
        step();
        drive(1'b0, OP_MULT, 32'd0, 32'd0);
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_busy",   32'(mdu_bus.busy), 32'd0);
        check_eq("arst_alu_op", 32'(mdu_bus.alu_op), 32'd5);
        check_eq("arst_alu_x",  mdu_bus.alu_x, 32'd0);
        check_eq("arst_hi",     mdu_bus.hi, 32'd0);
        check_eq("arst_lo",     mdu_bus.lo, 32'd0);
        step();
        rst = 1'b0;
        step();
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        #1;
        check_eq("arst_mflo",  mdu_bus.rd_data, 32'd0);
        check_eq("arst_stall", 32'(mdu_bus.stall), 32'd0);
        drive(1'b0, OP_MULT, 32'd0, 32'd0);
        repeat (20) step();
        check_eq("arst_no_wb_lo", mdu_bus.lo, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
